// File: rtl/eh2_bp_ghr_ckpt.sv
// Per-thread speculative/committed GHR with checkpoint FIFO and registered BHT index hash.
// Optional: define RV_GHR_LOOKUP_BYPASS_EN to hash same-cycle GHR updates into the lookup.
module eh2_bp_ghr_ckpt #(
    parameter int NUM_THREADS = 2,
    parameter int GHR_SIZE    = 8,
    parameter int IDX_WIDTH   = 8,
    parameter int CKPT_DEPTH  = 4,
    parameter int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   pred_valid,
    input  logic [TW-1:0]          pred_tid,
    input  logic                   pred_taken,
    output logic [NUM_THREADS-1:0] pred_ready,
    input  logic                   resolve_valid,
    input  logic [TW-1:0]          resolve_tid,
    input  logic                   resolve_taken,
    input  logic                   resolve_mispredict,
    input  logic                   flush_valid,
    input  logic [TW-1:0]          flush_tid,
    input  logic                   lookup_valid,
    input  logic [TW-1:0]          lookup_tid,
    input  logic [IDX_WIDTH-1:0]   lookup_idx,
    output logic                   hash_valid,
    output logic [IDX_WIDTH-1:0]   hash_idx
);

    localparam int PW     = $clog2(CKPT_DEPTH);
    localparam int CW     = $clog2(CKPT_DEPTH + 1);
    localparam int NCHUNK = (GHR_SIZE + IDX_WIDTH - 1) / IDX_WIDTH;

    typedef logic [GHR_SIZE-1:0] ghr_t;

    ghr_t          r_spec   [NUM_THREADS];
    ghr_t          r_commit [NUM_THREADS];
    ghr_t          r_fifo   [NUM_THREADS][CKPT_DEPTH];
    logic [PW-1:0] r_wptr   [NUM_THREADS];
    logic [PW-1:0] r_rptr   [NUM_THREADS];
    logic [CW-1:0] r_count  [NUM_THREADS];

    ghr_t          w_spec_nxt   [NUM_THREADS];
    ghr_t          w_commit_nxt [NUM_THREADS];
    logic          w_push       [NUM_THREADS];
    logic          w_pop        [NUM_THREADS];
    logic          w_clear      [NUM_THREADS];
    logic          w_pred_ok    [NUM_THREADS];
    logic          w_misp       [NUM_THREADS];
    logic          w_flush      [NUM_THREADS];
    ghr_t          w_ghr_sel;

    function automatic logic [IDX_WIDTH-1:0] fold(input ghr_t g);
        logic [NCHUNK*IDX_WIDTH-1:0] pad;
        logic [IDX_WIDTH-1:0]        acc;
        pad = '0;
        pad[GHR_SIZE-1:0] = g;
        acc = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            acc = acc ^ pad[c*IDX_WIDTH +: IDX_WIDTH];
        end
        return acc;
    endfunction

    // Priority per thread: flush > mispredict > prediction; correct resolve and push may coexist.
    always_comb begin
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            w_pred_ok[t]    = pred_valid && (pred_tid == TW'(t)) && (r_count[t] != CW'(CKPT_DEPTH));
            w_pop[t]        = resolve_valid && (resolve_tid == TW'(t)) && (r_count[t] != '0);
            w_misp[t]       = w_pop[t] && resolve_mispredict;
            w_flush[t]      = flush_valid && (flush_tid == TW'(t));
            w_clear[t]      = w_flush[t] || w_misp[t];
            w_push[t]       = w_pred_ok[t] && !w_clear[t];
            w_commit_nxt[t] = w_pop[t] ? ghr_t'({r_commit[t], resolve_taken}) : r_commit[t];
            w_spec_nxt[t]   = r_spec[t];
            if (w_flush[t]) begin
                w_spec_nxt[t] = w_commit_nxt[t];
            end else if (w_misp[t]) begin
                w_spec_nxt[t] = ghr_t'({r_fifo[t][r_rptr[t]], resolve_taken});
            end else if (w_push[t]) begin
                w_spec_nxt[t] = ghr_t'({r_spec[t], pred_taken});
            end
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pred_ready[t] = (r_count[t] != CW'(CKPT_DEPTH));
        end
    end

    always_comb begin
        w_ghr_sel = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (lookup_tid == TW'(t)) begin
`ifdef RV_GHR_LOOKUP_BYPASS_EN
                w_ghr_sel = w_spec_nxt[t];
`else
                w_ghr_sel = r_spec[t];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                r_spec[t]   <= '0;
                r_commit[t] <= '0;
                r_wptr[t]   <= '0;
                r_rptr[t]   <= '0;
                r_count[t]  <= '0;
                for (int unsigned d = 0; d < CKPT_DEPTH; d++) begin
                    r_fifo[t][d] <= '0;
                end
            end
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                r_spec[t]   <= w_spec_nxt[t];
                r_commit[t] <= w_commit_nxt[t];
                if (w_clear[t]) begin
                    r_wptr[t]  <= '0;
                    r_rptr[t]  <= '0;
                    r_count[t] <= '0;
                end else begin
                    if (w_push[t]) begin
                        r_fifo[t][r_wptr[t]] <= r_spec[t];
                        r_wptr[t]            <= r_wptr[t] + 1'b1;
                    end
                    if (w_pop[t]) begin
                        r_rptr[t] <= r_rptr[t] + 1'b1;
                    end
                    case ({w_push[t], w_pop[t]})
                        2'b10:   r_count[t] <= r_count[t] + 1'b1;
                        2'b01:   r_count[t] <= r_count[t] - 1'b1;
                        default: r_count[t] <= r_count[t];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hash_valid <= 1'b0;
            hash_idx   <= '0;
        end else begin
            hash_valid <= lookup_valid;
            if (lookup_valid) begin
                hash_idx <= lookup_idx ^ fold(w_ghr_sel);
            end
        end
    end

endmodule

// File: tb/tb_eh2_bp_ghr_ckpt.sv
// Self-checking bench for eh2_bp_ghr_ckpt: directed test-plan steps followed by random traffic
// against a queue-based history model.
module tb_eh2_bp_ghr_ckpt;

    localparam int NT    = 2;
    localparam int G     = 8;
    localparam int IW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          pred_valid, pred_taken;
    logic [0:0]    pred_tid;
    logic [NT-1:0] pred_ready;
    logic          resolve_valid, resolve_taken, resolve_mispredict;
    logic [0:0]    resolve_tid;
    logic          flush_valid;
    logic [0:0]    flush_tid;
    logic          lookup_valid;
    logic [0:0]    lookup_tid;
    logic [IW-1:0] lookup_idx;
    logic          hash_valid;
    logic [IW-1:0] hash_idx;

    eh2_bp_ghr_ckpt #(
        .NUM_THREADS (NT),
        .GHR_SIZE    (G),
        .IDX_WIDTH   (IW),
        .CKPT_DEPTH  (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .pred_valid         (pred_valid),
        .pred_tid           (pred_tid),
        .pred_taken         (pred_taken),
        .pred_ready         (pred_ready),
        .resolve_valid      (resolve_valid),
        .resolve_tid        (resolve_tid),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .flush_valid        (flush_valid),
        .flush_tid          (flush_tid),
        .lookup_valid       (lookup_valid),
        .lookup_tid         (lookup_tid),
        .lookup_idx         (lookup_idx),
        .hash_valid         (hash_valid),
        .hash_idx           (hash_idx)
    );

    always #5 clk = ~clk;

    // Reference model: histories as plain values, checkpoints as queues of history snapshots.
    logic [G-1:0]  m_spec   [NT];
    logic [G-1:0]  m_commit [NT];
    logic [G-1:0]  m_q      [NT][$];
    logic          exp_valid;
    logic [IW-1:0] exp_idx;
    int            errors = 0;
    int            checks = 0;
`ifdef RV_GHR_LOOKUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [IW-1:0] mfold(input logic [G-1:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < G; i++) r[i % IW] = r[i % IW] ^ g[i];
        return r;
    endfunction

    function automatic logic [G-1:0] shl(input logic [G-1:0] h, input logic b);
        return (h << 1) | G'(b);
    endfunction

    task automatic idle();
        pred_valid = 0; pred_tid = 0; pred_taken = 0;
        resolve_valid = 0; resolve_tid = 0; resolve_taken = 0; resolve_mispredict = 0;
        flush_valid = 0; flush_tid = 0;
        lookup_valid = 0; lookup_tid = 0; lookup_idx = '0;
    endtask

    task automatic check(input string tag);
        logic [NT-1:0] exp_rdy;
        for (int t = 0; t < NT; t++) exp_rdy[t] = (m_q[t].size() < DEPTH);
        checks++;
        assert (hash_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s hash_valid: got %b expected %b", tag, hash_valid, exp_valid);
        end
        checks++;
        assert (hash_idx === exp_idx) else begin
            errors++;
            $error("FAIL %s hash_idx: got %h expected %h", tag, hash_idx, exp_idx);
        end
        checks++;
        assert (pred_ready === exp_rdy) else begin
            errors++;
            $error("FAIL %s pred_ready: got %b expected %b", tag, pred_ready, exp_rdy);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < NT; t++) begin
            m_spec[t] = '0; m_commit[t] = '0; m_q[t].delete();
        end
        exp_valid = 0; exp_idx = '0;
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst_l = 0;
        #1;
        model_clear();
        check(tag);
        @(posedge clk); #1;
        rst_l = 1;
    endtask

    // One clock with the currently driven inputs; model advances, then outputs are checked.
    task automatic cyc(input string tag);
        logic [G-1:0] nspec [NT];
        logic [G-1:0] popped;
        bit pok, rok;
        for (int t = 0; t < NT; t++) begin
            nspec[t] = m_spec[t];
            pok = pred_valid && int'(pred_tid) == t && m_q[t].size() < DEPTH;
            rok = resolve_valid && int'(resolve_tid) == t && m_q[t].size() > 0;
            popped = '0;
            if (rok) begin
                popped = m_q[t].pop_front();
                m_commit[t] = shl(m_commit[t], resolve_taken);
            end
            if (flush_valid && int'(flush_tid) == t) begin
                nspec[t] = m_commit[t];
                m_q[t].delete();
            end else if (rok && resolve_mispredict) begin
                nspec[t] = shl(popped, resolve_taken);
                m_q[t].delete();
            end else if (pok) begin
                m_q[t].push_back(m_spec[t]);
                nspec[t] = shl(m_spec[t], pred_taken);
            end
        end
        if (lookup_valid)
            exp_idx = lookup_idx ^ mfold(BYPASS ? nspec[lookup_tid] : m_spec[lookup_tid]);
        exp_valid = lookup_valid;
        @(posedge clk); #1;
        for (int t = 0; t < NT; t++) m_spec[t] = nspec[t];
        check(tag);
    endtask

    task automatic pred(input logic tid, input logic tk, input string tag);
        idle(); pred_valid = 1; pred_tid = tid; pred_taken = tk; cyc(tag);
    endtask

    task automatic resolve(input logic tid, input logic tk, input logic mp, input string tag);
        idle(); resolve_valid = 1; resolve_tid = tid; resolve_taken = tk; resolve_mispredict = mp;
        cyc(tag);
    endtask

    task automatic lookup(input logic tid, input logic [IW-1:0] idx, input string tag);
        idle(); lookup_valid = 1; lookup_tid = tid; lookup_idx = idx; cyc(tag);
    endtask

    initial begin
        idle();
        rst_l = 0;
        model_clear();
        @(posedge clk); #1;
        do_reset("reset");

        lookup(0, 8'h5A, "lookup_5a");
        idle(); cyc("hold_idx");

        pred(0, 1, "p0_T"); pred(0, 0, "p0_N"); pred(0, 1, "p0_T2");
        lookup(0, 8'hF0, "lookup_f0");
        pred(0, 1, "p0_full");
        pred(0, 0, "p0_ignored");
        lookup(0, 8'h00, "spec_after_full");
        resolve(0, 1, 0, "res_correct");
        idle(); cyc("ready_back");
        idle(); pred_valid = 1; pred_tid = 0; pred_taken = 0;
        resolve_valid = 1; resolve_tid = 0; resolve_taken = 0; cyc("pred_and_resolve");

        do_reset("reset2");
        pred(0, 1, "m_p1"); pred(0, 1, "m_p2");
        resolve(0, 1, 0, "m_r1"); resolve(0, 1, 0, "m_r2");
        pred(0, 1, "m_p3"); pred(0, 1, "m_p4");
        lookup(0, 8'h00, "spec_0f");
        resolve(0, 0, 1, "mispredict");
        lookup(0, 8'h00, "spec_06");
        idle(); flush_valid = 1; flush_tid = 0; cyc("flush0_commit");
        lookup(0, 8'h00, "commit_06");

        pred(1, 1, "t1_p1"); pred(1, 1, "t1_p2");
        idle(); flush_valid = 1; flush_tid = 1; pred_valid = 1; pred_tid = 1; pred_taken = 1;
        cyc("flush1_drop_pred");
        lookup(1, 8'h00, "spec1_zero");
        lookup(0, 8'h33, "tid0_intact");

        do_reset("reset3");
        idle(); pred_valid = 1; pred_tid = 0; pred_taken = 1;
        lookup_valid = 1; lookup_tid = 0; lookup_idx = 8'h00; cyc("bypass_pred");
        idle(); resolve_valid = 1; resolve_tid = 0; resolve_taken = 1; resolve_mispredict = 1;
        lookup_valid = 1; lookup_tid = 0; lookup_idx = 8'hA5; cyc("bypass_misp");
        lookup(0, 8'h00, "misp_next_cycle");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #3;
                do_reset("async_reset_mid");
            end
            idle();
            pred_valid         = ($urandom_range(3) != 0);
            pred_tid           = 1'($urandom_range(1));
            pred_taken         = 1'($urandom_range(1));
            resolve_valid      = ($urandom_range(2) == 0);
            resolve_tid        = 1'($urandom_range(1));
            resolve_taken      = 1'($urandom_range(1));
            resolve_mispredict = ($urandom_range(4) == 0);
            flush_valid        = ($urandom_range(15) == 0);
            flush_tid          = 1'($urandom_range(1));
            lookup_valid       = ($urandom_range(3) != 0);
            lookup_tid         = 1'($urandom_range(1));
            lookup_idx         = 8'($urandom);
            cyc("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
